// File: rtl/bp_stall_counter_bank_if.sv
// bp_stall_counter_bank_if: host read port of the stall counter bank.
// Ports: req_v_i/req_ready_o/req_addr_i/req_clear_i request, resp_v_o/resp_ready_i/resp_data_o/resp_err_o response.
interface bp_stall_counter_bank_if #(
    parameter int addr_width_p = 7,
    parameter int cnt_width_p  = 64
);
    logic                    req_v_i;
    logic                    req_ready_o;
    logic [addr_width_p-1:0] req_addr_i;
    logic                    req_clear_i;
    logic                    resp_v_o;
    logic                    resp_ready_i;
    logic [cnt_width_p-1:0]  resp_data_o;
    logic                    resp_err_o;

    modport master (
        output req_v_i, req_addr_i, req_clear_i, resp_ready_i,
        input  req_ready_o, resp_v_o, resp_data_o, resp_err_o
    );

    modport slave (
        input  req_v_i, req_addr_i, req_clear_i, resp_ready_i,
        output req_ready_o, resp_v_o, resp_data_o, resp_err_o
    );
endinterface

// File: rtl/bp_stall_counter_bank.sv
// bp_stall_counter_bank: per-reason stall, retired-instr and sampled-cycle counters.
// Ports: clk_i, reset_li (async low), enable_i, freeze_i, sample_v_i, instret_i,
//        reason_i, clear_all_i, rd_if (slave read port), bad_reason_o (sticky).
module bp_stall_counter_bank #(
    parameter int num_reasons_p  = 64,
    parameter int reason_width_p = 6,
    parameter int cnt_width_p    = 64,
    parameter int addr_width_p   = 7
) (
    input  logic                      clk_i,
    input  logic                      reset_li,
    input  logic                      enable_i,
    input  logic                      freeze_i,
    input  logic                      sample_v_i,
    input  logic                      instret_i,
    input  logic [reason_width_p-1:0] reason_i,
    input  logic                      clear_all_i,
    bp_stall_counter_bank_if.slave    rd_if,
    output logic                      bad_reason_o
);

    localparam int num_cnt_lp   = num_reasons_p + 2;
    localparam int instr_idx_lp = num_reasons_p;
    localparam int cycle_idx_lp = num_reasons_p + 1;

    localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;
    localparam logic [reason_width_p:0] num_reasons_lp =
        (reason_width_p+1)'(num_reasons_p);
    localparam logic [addr_width_p-1:0] last_addr_lp =
        addr_width_p'(cycle_idx_lp);

    typedef enum logic {e_idle, e_resp} state_e;

    state_e state_r, state_n;

    logic                   cnt_en;
    logic                   reason_ok;
    logic                   accept;
    logic                   addr_ok;
    logic [cnt_width_p-1:0] cnt_r [num_cnt_lp];
    logic [num_cnt_lp-1:0]  inc;
    logic [num_cnt_lp-1:0]  rd_clr;
    logic [cnt_width_p-1:0] rd_val;

    assign cnt_en    = enable_i & ~freeze_i & sample_v_i;
    assign reason_ok = {1'b0, reason_i} < num_reasons_lp;
    assign accept    = rd_if.req_v_i & (state_r == e_idle);
    assign addr_ok   = rd_if.req_addr_i <= last_addr_lp;

    // Out-of-range reasons match no reason slot; out-of-range
    // addresses match no clear slot, so such clears are dropped.
    always_comb begin
        inc    = '0;
        rd_clr = '0;
        for (int i = 0; i < num_reasons_p; i++) begin
            inc[i] = cnt_en & ~instret_i &
                     (reason_i == reason_width_p'(i));
        end
        inc[instr_idx_lp] = cnt_en & instret_i;
        inc[cycle_idx_lp] = cnt_en;
        for (int i = 0; i < num_cnt_lp; i++) begin
            rd_clr[i] = accept & rd_if.req_clear_i &
                        (rd_if.req_addr_i == addr_width_p'(i));
        end
    end

    // A cleared-on-read counter keeps this cycle's event.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int i = 0; i < num_cnt_lp; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_cnt_lp; i++) begin
                if (clear_all_i) begin
                    cnt_r[i] <= '0;
                end else if (rd_clr[i]) begin
                    cnt_r[i] <= {{(cnt_width_p-1){1'b0}}, inc[i]};
                end else if (inc[i] && (cnt_r[i] != cnt_max_lp)) begin
                    cnt_r[i] <= cnt_r[i] + cnt_width_p'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            bad_reason_o <= 1'b0;
        end else if (clear_all_i) begin
            bad_reason_o <= 1'b0;
        end else if (cnt_en & ~instret_i & ~reason_ok) begin
            bad_reason_o <= 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < num_cnt_lp; i++) begin
            if (rd_if.req_addr_i == addr_width_p'(i)) begin
                rd_val = cnt_r[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle: if (rd_if.req_v_i)      state_n = e_resp;
            e_resp: if (rd_if.resp_ready_i) state_n = e_idle;
            default:                        state_n = e_idle;
        endcase
    end

    always_comb begin
        rd_if.req_ready_o = (state_r == e_idle);
        rd_if.resp_v_o    = (state_r == e_resp);
    end

    // Captured only on acceptance, so it holds through RESP.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            rd_if.resp_data_o <= '0;
            rd_if.resp_err_o  <= 1'b0;
        end else if (accept) begin
            rd_if.resp_data_o <= addr_ok ? rd_val : '0;
            rd_if.resp_err_o  <= ~addr_ok;
        end
    end

endmodule
